// File: rtl/mdu_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_divider_if
// Description : Handshake and data bundle between the execute stage and the
//               iterative RV32M divider.
//               master : pipeline side (drives start/op/src_a/src_b/abort)
//               slave  : divider side  (drives div_stall/done/result)
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_divider_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            abort;
    logic            div_stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, src_a, src_b, abort,
        input  div_stall, done, result
    );

    modport slave (
        input  start, op, src_a, src_b, abort,
        output div_stall, done, result
    );
endinterface
`default_nettype wire

// File: rtl/mdu_divider.sv
`default_nettype none
// ============================================================================
// Module      : mdu_divider
// Description : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/
//               REMU. One operand-accept cycle, XLEN iteration cycles and one
//               DONE cycle in which the registered result is valid.
//               Divide-by-zero and signed overflow finish straight from the
//               accept cycle.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               bus (slave)     - start/op/src_a/src_b/abort in,
//                                 div_stall/done/result out
// Options     : DIV_EARLY_OUT_EN - when defined, |dividend| < |divisor|
//               completes from the accept cycle (quotient 0, remainder
//               src_a).
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_divider #(
    parameter int XLEN = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mdu_divider_if.slave      bus
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   c_ITER    = CW'(XLEN);
    localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic            r_sel_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    // ------------------------------------------------------------------
    // Accept-cycle decode
    // ------------------------------------------------------------------
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_early_out;
    logic            w_accept;
    logic [XLEN-1:0] w_spec_q;
    logic [XLEN-1:0] w_spec_r;

    assign w_signed   = ~bus.op[0];
    assign w_a_neg    = w_signed & bus.src_a[XLEN-1];
    assign w_b_neg    = w_signed & bus.src_b[XLEN-1];
    // Negating INT_MIN wraps to itself, which is the correct unsigned magnitude.
    assign w_a_mag    = w_a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
    assign w_b_mag    = w_b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
    assign w_div_zero = (bus.src_b == '0);
    assign w_ovf      = w_signed & (bus.src_a == c_INT_MIN) & (bus.src_b == '1);
    assign w_accept   = (r_state == S_IDLE) & bus.start & ~bus.abort;
    assign w_spec_q   = w_div_zero ? '1 : c_INT_MIN;
    assign w_spec_r   = w_div_zero ? bus.src_a : '0;

`ifdef DIV_EARLY_OUT_EN
    assign w_early_out = (w_a_mag < w_b_mag);
`else
    assign w_early_out = 1'b0;
`endif

    // ------------------------------------------------------------------
    // One restoring-division step. The shifted partial remainder is one
    // bit wider than XLEN because it can reach 2*|divisor|-1.
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_fits;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [XLEN-1:0] w_q_fin;
    logic [XLEN-1:0] w_r_fin;
    logic [XLEN-1:0] w_res_fin;

    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_fits    = (w_shift >= {1'b0, r_dvs});
    assign w_diff    = w_shift - {1'b0, r_dvs};
    // Either candidate is below |divisor| here, so the top bit is always zero.
    assign w_rem_nxt = XLEN'(w_fits ? w_diff : w_shift);
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_fits};
    assign w_q_fin   = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    assign w_r_fin   = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    assign w_res_fin = r_sel_rem ? w_r_fin : w_q_fin;

    // The stall is combinational so the hazard unit freezes the front end
    // in the very cycle the instruction is accepted.
    assign bus.div_stall = w_accept | ((r_state == S_BUSY) & ~bus.abort);
    assign bus.done      = r_done;
    assign bus.result    = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else if (bus.abort) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sel_rem <= bus.op[1];
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_dvs     <= w_b_mag;
                        r_quo     <= w_a_mag;
                        r_rem     <= '0;
                        if (w_div_zero || w_ovf) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= bus.op[1] ? w_spec_r : w_spec_q;
                        end else if (w_early_out) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= bus.op[1] ? bus.src_a : '0;
                        end else begin
                            r_count <= c_ITER;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_rem   <= w_rem_nxt;
                    r_quo   <= w_quo_nxt;
                    r_count <= r_count - 1'b1;
                    if (r_count == CW'(1)) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_res_fin;
                    end
                end
                S_DONE: begin
                    // start is still the same instruction here; never restart.
                    r_state  <= S_IDLE;
                    r_done   <= 1'b0;
                    r_result <= '0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_done   <= 1'b0;
                    r_result <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_divider
// Description : Self-checking bench for mdu_divider. Directed cases plus
//               randomized operations compared against an arithmetic
//               reference of the RV32M division rules, including latency
//               and stall-length checks, abort and mid-operation reset.
// Options     : DIV_EARLY_OUT_EN - expected latencies follow the define.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_divider;

    localparam int XLEN = 32;
    localparam logic [31:0] c_INT_MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mdu_divider_if #(.XLEN(XLEN)) bus();

    mdu_divider #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: RV32M semantics in plain arithmetic
    // ------------------------------------------------------------------
    function automatic logic [31:0] ref_div(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == c_INT_MIN && b == 32'hFFFF_FFFF) begin
            q = c_INT_MIN;
            r = 32'd0;
        end else if (!op[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    // E-stage residency in cycles (accept through DONE)
    function automatic int ref_cycles(input logic [1:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (!op[0] && a[31]) ? 32'(0 - a) : a;
        mb = (!op[0] && b[31]) ? 32'(0 - b) : b;
        if (b == 32'd0) return 2;
        if (!op[0] && a == c_INT_MIN && b == 32'hFFFF_FFFF) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 2;
`else
        if (ma < mb) return 34;
`endif
        return 34;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one divide with start held until done. Called at posedge+1;
    // returns at posedge+1 after the DONE cycle with start still high.
    // Operands are scrambled after the accept cycle.
    task automatic run_div(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, output int stall_n,
                           output int total, output logic [31:0] res,
                           output logic seen);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        stall_n = 0;
        total   = 0;
        seen    = 1'b0;
        res     = '0;
        while (!seen && total < 100) begin
            @(negedge clk);
            total++;
            if (bus.div_stall) stall_n++;
            if (bus.done) begin
                seen = 1'b1;
                res  = bus.result;
            end
            tick();
            if (total == 1) begin
                bus.src_a = $urandom;
                bus.src_b = $urandom;
            end
        end
    endtask

    task automatic directed(input string tag, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res);
        int          st;
        int          tot;
        logic [31:0] res;
        logic        seen;
        int          cyc;
        cyc = ref_cycles(op, a, b);
        run_div(op, a, b, st, tot, res, seen);
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_result"}, res, exp_res);
        chk({tag, "_stall_cycles"}, 32'(st), 32'(cyc - 1));
        chk({tag, "_latency"}, 32'(tot), 32'(cyc));
    endtask

    initial begin
        int          st;
        int          tot;
        logic [31:0] res;
        logic        seen;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_stall", 32'(bus.div_stall), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", bus.result, 32'd0);
        tick();

        // Basic unsigned, done pulse is one cycle wide
        directed("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_pulse_width", 32'(bus.done), 32'd0);
        chk("result_zero_after", bus.result, 32'd0);
        tick();
        directed("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
        bus.start = 1'b0;
        tick();

        // Signed
        directed("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        directed("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
        directed("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2);
        bus.start = 1'b0;
        tick();

        // Special cases
        directed("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
        directed("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5);
        directed("div_ovf", 2'b00, c_INT_MIN, 32'hFFFF_FFFF, c_INT_MIN);
        directed("rem_ovf", 2'b10, c_INT_MIN, 32'hFFFF_FFFF, 32'd0);
        bus.start = 1'b0;
        tick();

        // Back-to-back: start never drops between the two instructions
        directed("b2b_first", 2'b01, 32'd10, 32'd3, 32'd3);
        directed("b2b_second", 2'b01, 32'd9, 32'd3, 32'd3);
        bus.start = 1'b0;
        tick();

        // Abort after ten iterations
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        @(negedge clk);
        chk("abort_accept_stall", 32'(bus.div_stall), 32'd1);
        tick();
        repeat (10) begin
            @(negedge clk);
            tick();
        end
        bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_cycle_stall", 32'(bus.div_stall), 32'd0);
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("post_abort_stall", 32'(bus.div_stall), 32'd0);
        chk("post_abort_done", 32'(bus.done), 32'd0);
        tick();
        directed("after_abort_divu_21_4", 2'b01, 32'd21, 32'd4, 32'd5);
        bus.start = 1'b0;
        tick();

        // Reset in the middle of BUSY
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.src_a = 32'd77;
        bus.src_b = 32'd5;
        @(negedge clk);
        tick();
        repeat (5) begin
            @(negedge clk);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("midrst_stall", 32'(bus.div_stall), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        tick();

        // Smaller dividend than divisor (early-out when enabled)
        directed("divu_3_9", 2'b01, 32'd3, 32'd9, 32'd0);
        directed("remu_3_9", 2'b11, 32'd3, 32'd9, 32'd3);
        directed("rem_m3_9", 2'b10, 32'hFFFF_FFFD, 32'd9, 32'hFFFF_FFFD);
        bus.start = 1'b0;
        tick();

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       begin ra = c_INT_MIN; rb = 32'hFFFF_FFFF; end
                2, 3:    rb = 32'($urandom_range(1, 20));
                4:       rb = 32'(0 - $urandom_range(1, 20));
                5:       begin rb = $urandom; ra = 32'($urandom_range(0, 50)); end
                default: rb = $urandom;
            endcase
            directed($sformatf("rand%0d", i), rop, ra, rb, ref_div(rop, ra, rb));
            if ($urandom_range(0, 1) == 1) begin
                bus.start = 1'b0;
                tick();
            end
        end
        bus.start = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_divider.md
Name: mdu_divider

Overview:
- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage beside the ALU.
- Produces `div_stall`, which the hazard unit uses to freeze the PC, F/D and D/E registers while a division is in flight.
- The division instruction stays in E for the whole operation; the result is muxed into the E-stage result path in the cycle `done` is high.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  E stage holds a valid divide-class instruction (opcode 0110011, funct7 0000001, funct3[2]=1)
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- src_a  input  XLEN  dividend (forwarded rs1)
- src_b  input  XLEN  divisor (forwarded rs2)
- abort  input  1  cancel in-flight operation (E-stage flush)
- div_stall  output  1  to hazard unit; pipeline must hold
- done  output  1  result valid this cycle; instruction may leave E
- result  output  XLEN  quotient or remainder per op

Behaviour:
- Clock/reset: one clock `clk`; `rst` synchronous, active-high.
- Reset: state=IDLE, count=0, quotient/remainder registers=0, done=0, result=0. div_stall=0 unless start is high in IDLE (combinational term).
- States: IDLE, BUSY, DONE.
- IDLE:
  - If start & !abort: latch op, sign flags and operand magnitudes; div_stall=1 combinationally in the same cycle.
  - Divisor==0 or (signed op & src_a==0x80000000 & src_b==0xFFFFFFFF): load the special-case result and go to DONE.
  - Otherwise: count=XLEN, go to BUSY.
- BUSY:
  - div_stall=1.
  - Each cycle: shift {rem,quo} left 1; trial-subtract divisor magnitude from rem; on no borrow, keep the difference and set the quo LSB.
  - count decrements; when the final iteration completes (count 1->0), go to DONE.
- DONE:
  - div_stall=0, done=1, result valid.
  - The next edge returns to IDLE unconditionally.
  - start is ignored in DONE, because it is still the same instruction.
  - A back-to-back divide sees start in IDLE on the following cycle.
- Latency (E-stage residency):
  - Normal: XLEN+2 cycles (1 accept + XLEN iterate + 1 DONE); div_stall high XLEN+1 cycles.
  - Special case: 2 cycles; div_stall high 1 cycle.
- Signed ops (DIV/REM):
  - Operate on magnitudes.
  - Quotient negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops use raw operands.
- Special results:
  - Divide by zero: quotient = all ones, remainder = src_a.
  - Signed overflow: quotient = 0x80000000, remainder = 0.
- result: quotient for op[1]=0, remainder for op[1]=1; 0 outside DONE.
- Abort:
  - Asserted in any state: next state IDLE, done=0.
  - div_stall drops in the abort cycle.
  - The start term in IDLE is gated by !abort.
- Reset mid-operation: return to IDLE immediately with no stale done or result.
- Operand inputs are don't-care after the accept cycle; forwarding changes during BUSY must not affect the result.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined:
  - In the accept cycle, if |dividend| < |divisor| (unsigned compare of magnitudes, divisor non-zero), go directly to DONE with quotient=0 and remainder=src_a.
  - div_stall is high 1 cycle; the comparator adds one XLEN-bit compare on the accept path.
- When undefined: such operations take the full XLEN+2 cycles with an identical result.

Test Plan:
- DIVU 100/7, start held until done -> div_stall high 33 cycles; done pulses 1 cycle with result=14; REMU -> 2.
- DIV 0xFFFFFF9C(-100)/7 -> result 0xFFFFFFF2(-14); REM -> 0xFFFFFFFE(-2); REM 100/-7 -> 2.
- DIVU 5/0 -> 2-cycle residency, result 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Two DIVU back-to-back (10/3 then 9/3) -> one idle-free handoff; results 3 then 3; the second stalls a full 33 cycles; DONE of the first does not restart.
- Abort at iteration 10, then a fresh DIVU 21/4 -> div_stall low the cycle after abort; new result 5 with full latency.
- rst asserted mid-BUSY -> next cycle div_stall=0, done=0, result=0. With DIV_EARLY_OUT_EN defined, DIVU 3/9 -> div_stall 1 cycle, result 0, REMU 3.
